// File: rtl/pwm_level_decoder.sv
// -----------------------------------------------------------------------------
// pwm_level_decoder
//
// Purpose:
//   This is the receive-side decoder for the 3-phase LCD bias PWM waveform.
//   The waveform has a period of 3 clk. The number of high phases in one
//   period selects the 2-bit voltage code:
//     0 high phases -> 00
//     1 high phase  -> 01
//     2 high phases -> 10
//     3 high phases -> 11
//   A new code is accepted only after STABLE_FRAMES consecutive frames have
//   decoded to the same level. This filters out phase slips and frames caught
//   in the middle of a code change.
//
// Parameters:
//   STABLE_FRAMES : number of consecutive identical frame codes required
//                   before a code is accepted. Legal range is 1..15.
//
// Ports:
//   clk          in   1  system clock; all logic is on the rising edge.
//   rstn         in   1  reset, synchronous, active-low.
//   PWMIn        in   1  PWM bias waveform.
//   Voltage      out  2  accepted voltage code (registered).
//   VoltageValid out  1  high once a code has been accepted since reset.
//   VoltageChg   out  1  one-cycle pulse on every update of Voltage.
//
// Optional feature:
//   PWM_DEC_SYNC_EN - when this macro is defined, PWMIn passes through a
//   two-flop synchronizer before it is sampled. This adds two cycles of
//   input latency, and the first two samples after reset read 0.
// -----------------------------------------------------------------------------
module pwm_level_decoder #(
    parameter int unsigned STABLE_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       PWMIn,
    output logic [1:0] Voltage,
    output logic       VoltageValid,
    output logic       VoltageChg
);

    localparam logic [3:0] C_STABLE = 4'(STABLE_FRAMES);

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'b00,
        ST_LOCKED  = 2'b01,
        ST_PENDING = 2'b10
    } state_t;

    logic       w_sample;
    logic [1:0] w_lvl;
    logic       w_eval;
    logic [3:0] w_run_next;
    logic       w_stable;
    logic [1:0] w_phase_next;

    logic [1:0] r_phase;
    logic [1:0] r_sh;
    logic [1:0] r_cand;
    logic [3:0] r_run;
    state_t     r_state;
    logic [1:0] r_voltage;
    logic       r_valid;
    logic       r_chg;

`ifdef PWM_DEC_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    // Two-flop synchronizer for an asynchronous PWM input.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= PWMIn;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample = r_sync2;
`else
    assign w_sample = PWMIn;
`endif

    // Popcount of the three samples in the current frame window.
    // The maximum popcount is 3, so the sum fits in two bits without overflow.
    assign w_lvl  = {1'b0, r_sh[1]} + {1'b0, r_sh[0]} + {1'b0, w_sample};
    assign w_eval = (r_phase == 2'd2);

    // Next run length if this cycle is an evaluation. The run length
    // saturates at the threshold, so it never exceeds STABLE_FRAMES.
    always_comb begin
        w_run_next = 4'd1;
        if ((w_lvl == r_cand) && (r_run != 4'd0)) begin
            if (r_run >= C_STABLE) begin
                w_run_next = C_STABLE;
            end else begin
                w_run_next = r_run + 4'd1;
            end
        end else begin
            w_run_next = 4'd1;
        end
    end

    assign w_stable = (w_run_next == C_STABLE);

    // Free-running frame phase 0,1,2. The unreachable value 3 recovers to 0.
    always_comb begin
        w_phase_next = 2'd0;
        case (r_phase)
            2'd0:    w_phase_next = 2'd1;
            2'd1:    w_phase_next = 2'd2;
            2'd2:    w_phase_next = 2'd0;
            default: w_phase_next = 2'd0;
        endcase
    end

    // Sampling, frame evaluation, run tracking and the acceptance FSM.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_phase   <= 2'd0;
            r_sh      <= 2'b00;
            r_cand    <= 2'b00;
            r_run     <= 4'd0;
            r_state   <= ST_ACQUIRE;
            r_voltage <= 2'b00;
            r_valid   <= 1'b0;
            r_chg     <= 1'b0;
        end else begin
            r_sh    <= {r_sh[0], w_sample};
            r_phase <= w_phase_next;
            r_chg   <= 1'b0;
            if (w_eval) begin
                // When the level matches the candidate, the candidate is
                // unchanged. Otherwise the level becomes the new candidate.
                r_cand <= w_lvl;
                r_run  <= w_run_next;
                case (r_state)
                    ST_ACQUIRE: begin
                        if (w_stable) begin
                            r_voltage <= w_lvl;
                            r_valid   <= 1'b1;
                            r_chg     <= 1'b1;
                            r_state   <= ST_LOCKED;
                        end else begin
                            r_state   <= ST_ACQUIRE;
                        end
                    end
                    ST_LOCKED, ST_PENDING: begin
                        // In LOCKED the candidate always equals Voltage. A
                        // differing level therefore only reaches the
                        // threshold immediately when STABLE_FRAMES is 1,
                        // and that case must update without waiting.
                        if (w_lvl != r_voltage) begin
                            if (w_stable) begin
                                r_voltage <= w_lvl;
                                r_chg     <= 1'b1;
                                r_state   <= ST_LOCKED;
                            end else begin
                                r_state   <= ST_PENDING;
                            end
                        end else begin
                            // Level returned to the accepted code: the
                            // transient is rejected and no pulse is raised.
                            r_state <= ST_LOCKED;
                        end
                    end
                    default: begin
                        r_state <= ST_ACQUIRE;
                        r_valid <= 1'b0;
                    end
                endcase
            end else begin
                r_state <= r_state;
            end
        end
    end

    assign Voltage      = r_voltage;
    assign VoltageValid = r_valid;
    assign VoltageChg   = r_chg;

endmodule

// File: tb/tb_pwm_level_decoder.sv
// -----------------------------------------------------------------------------
// tb_pwm_level_decoder
//
// Testbench for pwm_level_decoder in the default build (no input
// synchronizer), with STABLE_FRAMES = 2.
//
// The reference model works from the decoding rules rather than from the
// design's structure:
//   - Every third sample after reset release closes a frame.
//   - A frame's level is the number of ones in its last three samples.
//   - A code is accepted when the last STABLE_FRAMES frame levels are all
//     equal and that level differs from the current code, or when no code
//     has been accepted yet.
// -----------------------------------------------------------------------------
module tb_pwm_level_decoder;

    localparam int SF = 2;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       pwm_in = 1'b0;
    logic [1:0] voltage;
    logic       voltage_valid;
    logic       voltage_chg;

    int    n_checks = 0;
    int    n_pass   = 0;
    string stage    = "init";

    // Reference model state.
    int         m_k;
    bit         m_win[$];
    int         m_frames[$];
    logic [1:0] m_volt;
    logic       m_valid;
    logic       m_chg;

    always #5 clk = ~clk;

    pwm_level_decoder #(.STABLE_FRAMES(SF)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .PWMIn       (pwm_in),
        .Voltage     (voltage),
        .VoltageValid(voltage_valid),
        .VoltageChg  (voltage_chg)
    );

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance the reference model by one rising edge.
    task automatic model_edge(input bit r, input bit s);
        int  lvl;
        bit  same;
        m_chg = 1'b0;
        if (!r) begin
            m_k = 0;
            m_win.delete();
            m_frames.delete();
            m_volt  = 2'd0;
            m_valid = 1'b0;
        end else begin
            m_win.push_back(s);
            if (m_win.size() > 3) begin
                void'(m_win.pop_front());
            end
            if (m_k % 3 == 2) begin
                lvl = 0;
                foreach (m_win[i]) lvl += int'(m_win[i]);
                m_frames.push_back(lvl);
                if (m_frames.size() > SF) begin
                    void'(m_frames.pop_front());
                end
                same = (m_frames.size() == SF);
                foreach (m_frames[i]) begin
                    if (m_frames[i] != lvl) same = 1'b0;
                end
                if (same && (!m_valid || (2'(lvl) != m_volt))) begin
                    m_volt  = 2'(lvl);
                    m_valid = 1'b1;
                    m_chg   = 1'b1;
                end
            end
            m_k++;
        end
    endtask

    // Run one clock cycle: drive inputs, update the model, then check outputs.
    task automatic step(input bit r, input bit s);
        @(negedge clk);
        rstn   = r;
        pwm_in = s;
        @(posedge clk);
        model_edge(r, s);
        #1;
        check_eq({stage, "/Voltage"},      {2'b00, voltage},      {2'b00, m_volt});
        check_eq({stage, "/VoltageValid"}, {3'b000, voltage_valid}, {3'b000, m_valid});
        check_eq({stage, "/VoltageChg"},   {3'b000, voltage_chg},   {3'b000, m_chg});
    endtask

    // Drive n cycles of the generator pattern for the given code.
    // ph is the generator phase and is carried across calls.
    task automatic gen(input int code, input int n, inout int ph);
        for (int i = 0; i < n; i++) begin
            step(1'b1, ph < code);
            ph = (ph + 1) % 3;
        end
    endtask

    initial begin
        int ph;
        int chg_seen;

        // Constant 1 from reset: the code becomes visible after cycle 5.
        stage = "const1";
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chg_seen = 0;
        for (int c = 0; c < 15; c++) begin
            step(1'b1, 1'b1);
            if (c == 5) check_eq("const1/first_visible", {2'b00, voltage}, 4'd3);
            if (c == 4) check_eq("const1/before_visible", {3'b000, voltage_valid}, 4'd0);
            chg_seen += int'(voltage_chg);
        end
        check_eq("const1/pulse_count", 4'(chg_seen), 4'd1);

        // Code 01 started at each of the three phase offsets.
        for (int off = 0; off < 3; off++) begin
            stage = $sformatf("code01_off%0d", off);
            step(1'b0, 1'b0);
            ph = off;
            gen(1, 12, ph);
            check_eq({stage, "/final"}, {2'b00, voltage}, 4'd1);
        end

        // Locked at 10, then switched to 11.
        stage = "10to11";
        step(1'b0, 1'b0);
        ph = 0;
        gen(2, 12, ph);
        gen(3, 12, ph);
        check_eq("10to11/final", {2'b00, voltage}, 4'd3);

        // Locked at 01, one frame of zeros, then 01 resumes.
        stage = "glitch";
        step(1'b0, 1'b0);
        ph = 0;
        gen(1, 12, ph);
        gen(0, 3, ph);
        gen(1, 12, ph);
        check_eq("glitch/final", {2'b00, voltage}, 4'd1);

        // Reset while a change is pending, then a full reacquisition.
        stage = "rst_pending";
        step(1'b0, 1'b0);
        ph = 0;
        gen(2, 12, ph);
        gen(3, 4, ph);
        step(1'b0, 1'b1);
        gen(3, 12, ph);

        // Random codes with phase slips, glitches and occasional resets.
        stage = "random";
        step(1'b0, 1'b0);
        ph = 0;
        for (int seg = 0; seg < 200; seg++) begin
            int code;
            int nfr;
            code = int'($urandom_range(0, 3));
            nfr  = int'($urandom_range(1, 4));
            if ($urandom_range(0, 39) == 0) begin
                step(1'b0, 1'b0);
            end
            if ($urandom_range(0, 9) == 0) begin
                ph = (ph + 1) % 3;
            end
            for (int i = 0; i < 3 * nfr; i++) begin
                bit b;
                b = (ph < code);
                if ($urandom_range(0, 29) == 0) b = ~b;
                step(1'b1, b);
                ph = (ph + 1) % 3;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
